// File: rtl/mult_arbiter_if.sv
// Requester-side bundle for mult_arbiter: per-requester operand handshake plus the response strobe.
interface mult_arbiter_if #(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_lock;
    logic [BIT_WIDTH-1:0] req_a [0:NUM_REQ-1];
    logic [BIT_WIDTH-1:0] req_b [0:NUM_REQ-1];
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [BIT_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_lock, req_a, req_b,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_lock, req_a, req_b,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbitrated, lockable, 2-stage pipelined fixed-point multiplier.
// Define MULT_ARBITER_SATURATE_EN to saturate instead of wrap on result overflow.
module mult_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int FRAC_BITS = 16
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mult_arbiter_if.slave bus
);
    localparam int IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StArb, StLocked} state_t;

    state_t               state_q, state_d;
    logic [IdxW-1:0]      last_grant_q, last_grant_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [IdxW-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 fire;

    logic                 s1_valid_q;
    logic [IdxW-1:0]      s1_id_q;
    logic [BIT_WIDTH-1:0] s1_a_q, s1_b_q;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [BIT_WIDTH-1:0] resp_data_q, result;

    logic signed [2*BIT_WIDTH-1:0] a_ext, b_ext, prod, shifted;

    always_comb begin : arb
        logic            found;
        logic [IdxW-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (!rst_in) begin
            if (state_q == StLocked) begin
                // Other requesters stay stalled even while the owner is idle.
                grant_idx      = owner_q;
                grant[owner_q] = bus.req_valid[owner_q];
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = IdxW'((int'(last_grant_q) + k) % NUM_REQ);
                    if (!found && bus.req_valid[cand]) begin
                        found       = 1'b1;
                        grant[cand] = 1'b1;
                        grant_idx   = cand;
                    end
                end
            end
        end
    end

    assign fire          = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if (fire) begin
            last_grant_d = grant_idx;
            if (state_q == StArb && bus.req_lock[grant_idx]) begin
                state_d = StLocked;
                owner_d = grant_idx;
            end else if (state_q == StLocked && !bus.req_lock[grant_idx]) begin
                state_d = StArb;
            end
        end
    end

    always_comb begin
        a_ext   = $signed({{BIT_WIDTH{s1_a_q[BIT_WIDTH-1]}}, s1_a_q});
        b_ext   = $signed({{BIT_WIDTH{s1_b_q[BIT_WIDTH-1]}}, s1_b_q});
        prod    = a_ext * b_ext;
        shifted = prod >>> FRAC_BITS;
        result  = shifted[BIT_WIDTH-1:0];
`ifdef MULT_ARBITER_SATURATE_EN
        // Fits only if every bit from BIT_WIDTH-1 upward matches the sign.
        if (shifted[2*BIT_WIDTH-1:BIT_WIDTH-1] != {(BIT_WIDTH+1){shifted[2*BIT_WIDTH-1]}}) begin
            result = shifted[2*BIT_WIDTH-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        resp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_d[i] = s1_valid_q && (s1_id_q == IdxW'(i));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StArb;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            owner_q      <= '0;
            s1_valid_q   <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            s1_valid_q   <= fire;
            resp_valid_q <= resp_valid_d;
            if (s1_valid_q) begin
                resp_data_q <= result;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        s1_id_q <= grant_idx;
        s1_a_q  <= bus.req_a[grant_idx];
        s1_b_q  <= bus.req_b[grant_idx];
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: grants checked inline per task, responses popped by a monitor.
module tb_mult_arbiter;
    localparam int W  = 32;
    localparam int NR = 4;
    localparam int FB = 16;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   checks;
    int   passed;
    logic [W-1:0] prev_data;
    logic         prev_rst;

    mult_arbiter_if #(.BIT_WIDTH(W), .NUM_REQ(NR)) bus ();

    mult_arbiter #(.BIT_WIDTH(W), .NUM_REQ(NR), .FRAC_BITS(FB)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        p = p >>> FB;
`ifdef MULT_ARBITER_SATURATE_EN
        if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (p < -64'sh8000_0000) return 32'h8000_0000;
`endif
        return p[W-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [W-1:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i] = '0;
            bus.req_b[i] = '0;
        end
    endtask

    // Two reset edges; returns just after the edge where rst drops, with the queue cleared.
    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        sb_q.delete();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid !== '0) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL resp_unexpected: resp_valid=%b with empty scoreboard", bus.resp_valid);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.resp_valid !== (4'b0001 << e.id)) begin
                    $display("FAIL resp_id: resp_valid=%b expected=%b", bus.resp_valid,
                             4'b0001 << e.id);
                end else if (bus.resp_data !== e.data) begin
                    $display("FAIL resp_data: got=%h expected=%h (req %0d)", bus.resp_data,
                             e.data, e.id);
                end else begin
                    passed++;
                end
            end
        end else if (!prev_rst && !rst) begin
            checks++;
            if (bus.resp_data !== prev_data) begin
                $display("FAIL resp_hold: got=%h expected=%h", bus.resp_data, prev_data);
            end else begin
                passed++;
            end
        end
        prev_data = bus.resp_data;
        prev_rst  = rst;
    end

    task automatic test_reset;
        tick();
        bus.req_valid = 4'b1111;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            $display("FAIL ready_in_reset: got=%b expected=0000", bus.req_ready);
        end else passed++;
        tick();
        sb_q.delete();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 4'b0000 || bus.resp_data !== '0) begin
            $display("FAIL reset_state: ready=%b resp_valid=%b resp_data=%h expected 0/0/0",
                     bus.req_ready, bus.resp_valid, bus.resp_data);
        end else passed++;
    endtask

    task automatic single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_data);
        tick();
        bus.req_valid     = 4'b0001 << id;
        bus.req_a[id]     = a;
        bus.req_b[id]     = b;
        #1;
        checks++;
        if (bus.req_ready !== (4'b0001 << id)) begin
            $display("FAIL single_ready_%0d: got=%b expected=%b", id, bus.req_ready,
                     4'b0001 << id);
        end else passed++;
        push(id, exp_data);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_single;
        single_op(2, 32'h0002_0000, 32'h0001_8000, 32'h0003_0000);
    endtask

    task automatic test_negative;
        single_op(1, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFD_0000);
    endtask

    task automatic test_overflow;
`ifdef MULT_ARBITER_SATURATE_EN
        single_op(3, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF);
`else
        single_op(3, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0001_0000);
`endif
    endtask

    task automatic test_fairness;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c != 0) tick();
            bus.req_valid = 4'b1111;
            for (int i = 0; i < NR; i++) begin
                bus.req_a[i] = 32'((c + 1) << 16);
                bus.req_b[i] = 32'((i + 2) << 15);
            end
            #1;
            checks++;
            if (bus.req_ready !== (4'b0001 << (c % 4))) begin
                $display("FAIL fair_grant_c%0d: got=%b expected=%b", c, bus.req_ready,
                         4'b0001 << (c % 4));
            end else passed++;
            push(c % 4, model(bus.req_a[c % 4], bus.req_b[c % 4]));
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_lock;
        logic [3:0] vs [6] = '{4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0111, 4'b0111};
        logic [3:0] ls [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] es [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c != 0) tick();
            bus.req_valid = vs[c];
            bus.req_lock  = ls[c];
            for (int i = 0; i < NR; i++) begin
                bus.req_a[i] = 32'((c + 1) << 16);
                bus.req_b[i] = 32'((i + 1) << 16);
            end
            #1;
            checks++;
            if (bus.req_ready !== es[c]) begin
                $display("FAIL lock_grant_c%0d: got=%b expected=%b", c, bus.req_ready, es[c]);
            end else passed++;
            for (int i = 0; i < NR; i++) begin
                if (es[c][i]) push(i, model(bus.req_a[i], bus.req_b[i]));
            end
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        tick();
        bus.req_valid = 4'b1000;
        bus.req_a[3]  = 32'h0001_0000;
        bus.req_b[3]  = 32'h0005_0000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            $display("FAIL mid_first_ready: got=%b expected=1000", bus.req_ready);
        end else passed++;
        push(3, 32'h0005_0000);
        tick();
        rst = 1'b1;
        sb_q.delete();
        bus.req_valid = 4'b1111;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            $display("FAIL mid_ready_in_reset: got=%b expected=0000", bus.req_ready);
        end else passed++;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.resp_valid !== 4'b0000) begin
            $display("FAIL mid_discard: resp_valid=%b expected=0000", bus.resp_valid);
        end else passed++;
        bus.req_a[0] = 32'h0002_0000;
        bus.req_b[0] = 32'h0002_0000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            $display("FAIL mid_post_reset_grant: got=%b expected=0001", bus.req_ready);
        end else passed++;
        push(0, 32'h0004_0000);
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (c != 0) tick();
            bus.req_valid = 4'b1111;
            for (int i = 0; i < NR; i++) begin
                bus.req_a[i] = $urandom;
                bus.req_b[i] = (c % 3 == 0) ? $urandom : $urandom_range(0, 32'h0004_0000);
            end
            #1;
            checks++;
            if (bus.req_ready !== (4'b0001 << (c % 4))) begin
                $display("FAIL b2b_grant_c%0d: got=%b expected=%b", c, bus.req_ready,
                         4'b0001 << (c % 4));
            end else passed++;
            push(c % 4, model(bus.req_a[c % 4], bus.req_b[c % 4]));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_drain;
        int budget;
        budget = 20;
        while (sb_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
        end else passed++;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        prev_data = '0;
        prev_rst  = 1'b1;
        rst       = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_negative();
        test_overflow();
        test_fairness();
        test_lock();
        test_reset_mid();
        test_back_to_back();
        test_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
